// File: rtl/timer_pkg.sv
// Shared types and helpers for the shift-loaded countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } timer_state_e;

  localparam int DELAY_W_DEF = 4;

  // Width of the per-unit prescaler; a minimum of one bit keeps degenerate values legal.
  function automatic int presc_w(input int cycles_per_count);
    return (cycles_per_count < 2) ? 1 : $clog2(cycles_per_count);
  endfunction

endpackage

// File: rtl/unit_tick_gen.sv
// Loadable down-counter that pulses tick_o once every CYCLES_PER_COUNT enabled cycles.
module unit_tick_gen
  import timer_pkg::*;
#(
  parameter int CYCLES_PER_COUNT = 1000
) (
  input  logic clk,
  input  logic srst_i,
  input  logic load_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int PW = presc_w(CYCLES_PER_COUNT);
  localparam logic [PW-1:0] RELOAD = PW'(CYCLES_PER_COUNT - 1);

  logic [PW-1:0] presc_q;

  assign tick_o = en_i && (presc_q == '0);

  // Reload on the tick itself so consecutive units are back to back.
  always_ff @(posedge clk) begin
    if (srst_i) begin
      presc_q <= '0;
    end else if (load_i) begin
      presc_q <= RELOAD;
    end else if (en_i) begin
      if (presc_q == '0) begin
        presc_q <= RELOAD;
      end else begin
        presc_q <= presc_q - PW'(1);
      end
    end
  end

endmodule

// File: rtl/shift_countdown_timer.sv
// Serially captures a delay value, then counts (delay+1) prescaled units and raises done until ack.
module shift_countdown_timer
  import timer_pkg::*;
#(
  parameter int CYCLES_PER_COUNT = 1000,
  parameter int DELAY_W          = DELAY_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_ena,
  input  logic               data,
  input  logic               ack,
  output logic [DELAY_W-1:0] count,
  output logic               counting,
  output logic               done
);

  timer_state_e       state_q;
  logic [DELAY_W-1:0] count_q;
  logic [DELAY_W-1:0] shifted;
  logic               tick;
  logic               presc_load;

  assign shifted    = {count_q[DELAY_W-2:0], data};
  assign presc_load = (state_q == LOAD) && !shift_ena;

  unit_tick_gen #(
    .CYCLES_PER_COUNT(CYCLES_PER_COUNT)
  ) u_tick (
    .clk   (clk),
    .srst_i(reset),
    .load_i(presc_load),
    .en_i  (state_q == COUNT),
    .tick_o(tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (shift_ena) begin
            count_q <= shifted;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (shift_ena) begin
            count_q <= shifted;
          end else begin
            state_q <= COUNT;
          end
        end
        COUNT: begin
          // A zero count exits instead of decrementing, so it can never wrap.
          if (tick) begin
            if (count_q != '0) begin
              count_q <= count_q - DELAY_W'(1);
            end else begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (ack) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign count    = count_q;
  assign counting = (state_q == COUNT);
  assign done     = (state_q == DONE);

endmodule
